frame_accumulator: RTL and testbench



---
 rtl/frame_accumulator.sv | 177 +++++++++++++++++
 tb/tb_frame_accumulator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_accumulator.sv
// Validates logger frames tapped from the pipe write stream, sums good frames into
// per-bin saturating accumulators, and streams the histogram out every nframes_i frames.
module frame_accumulator #(
    parameter int          NBINS   = 26,
    parameter logic [15:0] HEADER  = 16'hFEED,
    parameter logic [15:0] TRAILER = 16'h0FED
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_i,
    input  logic [15:0] data_i,
    input  logic        clear_i,
    input  logic [15:0] nframes_i,
    input  logic        rd_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic [15:0] frames_o,
    output logic [15:0] bad_cnt_o,
    output logic [15:0] drop_cnt_o,
    output logic        busy_o
);

    localparam logic [15:0] DUMP_HEAD = 16'hACC5;
    localparam logic [15:0] DUMP_TAIL = 16'h5CCA;
    localparam int          NWORDS    = 2 * NBINS + 3;
    localparam int          IW        = $clog2(NBINS);
    localparam int          DW        = $clog2(NWORDS);
    localparam logic [DW-1:0] LAST_IDX = DW'(NWORDS - 1);

    typedef enum logic [1:0] {HUNT, DATA, TRAIL, DUMP} state_t;

    state_t         state_q;
    logic [IW-1:0]  idx_q;
    logic [15:0]    stage_q [NBINS];
    logic [31:0]    acc_q   [NBINS];
    logic [31:0]    acc_sat [NBINS];
    logic [15:0]    frames_q;
    logic [15:0]    bad_q;
    logic [15:0]    drop_q;
    logic [15:0]    data_q;
    logic           valid_q;
    logic [DW-1:0]  widx_q;

    logic [15:0]    data_d;
    logic [15:0]    unswapped;
    logic [15:0]    frames_inc;
    logic [15:0]    bad_inc;
    logic [15:0]    drop_inc;
    logic [15:0]    nframes_eff;
    logic           xfer;
    logic [DW-1:0]  widx_nx;
    logic [DW-1:0]  woff;
    logic [DW-2:0]  wbin;

    // Every bin adds its staged count in the same cycle, clamping at all-ones.
    generate
        for (genvar gi = 0; gi < NBINS; gi++) begin : g_sat
            logic [32:0] sum;
            assign sum         = {1'b0, acc_q[gi]} + {17'd0, stage_q[gi]};
            assign acc_sat[gi] = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        end
    endgenerate

    assign unswapped   = {data_i[7:0], data_i[15:8]};
    assign frames_inc  = (frames_q == 16'hFFFF) ? frames_q : frames_q + 16'd1;
    assign bad_inc     = (bad_q    == 16'hFFFF) ? bad_q    : bad_q    + 16'd1;
    assign drop_inc    = (drop_q   == 16'hFFFF) ? drop_q   : drop_q   + 16'd1;
    assign nframes_eff = (nframes_i == 16'd0) ? 16'd1 : nframes_i;
    assign xfer        = valid_q & rd_i;

    // Word that follows the one currently presented: index 1 is the frame count,
    // 2..2*NBINS+1 alternate low/high halves of each bin, last is the tail marker.
    assign widx_nx = widx_q + DW'(1);
    assign woff    = widx_nx - DW'(2);
    assign wbin    = woff[DW-1:1];

    always_comb begin
        data_d = DUMP_TAIL;
        if (widx_nx == DW'(1)) begin
            data_d = frames_q;
        end else if (widx_nx != LAST_IDX && int'(wbin) < NBINS) begin
            data_d = woff[0] ? acc_q[wbin][31:16] : acc_q[wbin][15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i || clear_i) begin
            state_q  <= HUNT;
            idx_q    <= '0;
            frames_q <= '0;
            bad_q    <= '0;
            drop_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            widx_q   <= '0;
            for (int b = 0; b < NBINS; b++) begin
                stage_q[b] <= '0;
                acc_q[b]   <= '0;
            end
        end else begin
            case (state_q)
                HUNT: begin
                    if (wr_i && data_i == HEADER) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                    end
                end
                DATA: begin
                    if (wr_i) begin
                        stage_q[idx_q] <= unswapped;
                        if (idx_q == IW'(NBINS - 1)) begin
                            state_q <= TRAIL;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                TRAIL: begin
                    if (wr_i) begin
                        if (data_i == TRAILER) begin
                            for (int b = 0; b < NBINS; b++) begin
                                acc_q[b] <= acc_sat[b];
                            end
                            frames_q <= frames_inc;
                            if (frames_inc >= nframes_eff) begin
                                state_q <= DUMP;
                                valid_q <= 1'b1;
                                data_q  <= DUMP_HEAD;
                                widx_q  <= '0;
                            end else begin
                                state_q <= HUNT;
                            end
                        end else if (data_i == HEADER) begin
                            // A header in the trailer slot is treated as the start of a new frame.
                            bad_q   <= bad_inc;
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            bad_q   <= bad_inc;
                            state_q <= HUNT;
                        end
                    end
                end
                DUMP: begin
                    if (wr_i && data_i == HEADER) begin
                        drop_q <= drop_inc;
                    end
                    if (xfer) begin
                        if (widx_q == LAST_IDX) begin
                            state_q  <= HUNT;
                            valid_q  <= 1'b0;
                            data_q   <= '0;
                            widx_q   <= '0;
                            frames_q <= '0;
                            for (int b = 0; b < NBINS; b++) begin
                                stage_q[b] <= '0;
                                acc_q[b]   <= '0;
                            end
                        end else begin
                            widx_q <= widx_nx;
                            data_q <= data_d;
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign frames_o   = frames_q;
    assign bad_cnt_o  = bad_q;
    assign drop_cnt_o = drop_q;
    assign busy_o     = (state_q == DUMP);

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed bench for frame_accumulator: reset, single/multi-frame dumps, bad trailers,
// backpressure with injected frames, and clear during a dump.
module tb_frame_accumulator;

    localparam int          NB      = 26;
    localparam logic [15:0] HDR     = 16'hFEED;
    localparam logic [15:0] TRL     = 16'h0FED;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        wr_i;
    logic [15:0] data_i;
    logic        clear_i;
    logic [15:0] nframes_i;
    logic        rd_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic [15:0] frames_o;
    logic [15:0] bad_cnt_o;
    logic [15:0] drop_cnt_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0]     exp_w [64];
    int              exp_len;
    longint unsigned m_acc [NB];
    logic [15:0]     m_frames;

    frame_accumulator dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .wr_i       (wr_i),
        .data_i     (data_i),
        .clear_i    (clear_i),
        .nframes_i  (nframes_i),
        .rd_i       (rd_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frames_o   (frames_o),
        .bad_cnt_o  (bad_cnt_o),
        .drop_cnt_o (drop_cnt_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int k = 0; k < NB; k++) m_acc[k] = 0;
        m_frames = 16'd0;
    endtask

    // Bin k is sent on the wire as {base + k*inc, 8'h00}, i.e. count base + k*inc.
    task automatic send_frame(input bit with_hdr, input logic [7:0] base, input logic [7:0] inc,
                              input logic [15:0] trl, input bit model_it);
        if (with_hdr) begin
            wr_i = 1'b1; data_i = HDR; step();
        end
        for (int k = 0; k < NB; k++) begin
            logic [7:0] v;
            v = base + 8'(k) * inc;
            wr_i = 1'b1; data_i = {v, 8'h00}; step();
            if (model_it) m_acc[k] = m_acc[k] + 64'(v);
        end
        chk1("pre_trailer_valid", valid_o, 1'b0);
        wr_i = 1'b1; data_i = trl; step();
        wr_i = 1'b0;
        if (model_it) m_frames = m_frames + 16'd1;
    endtask

    task automatic build_exp();
        exp_w[0] = 16'hACC5;
        exp_w[1] = m_frames;
        for (int b = 0; b < NB; b++) begin
            longint unsigned a;
            a = m_acc[b];
            exp_w[2 + 2*b] = a[15:0];
            exp_w[3 + 2*b] = a[31:16];
        end
        exp_w[2*NB + 2] = 16'h5CCA;
        exp_len = 2*NB + 3;
    endtask

    // Walks the dump word by word; optional stall, frame injection and clear at a given word.
    task automatic run_dump(input int stall_at, input int stall_len, input bit inj, input int clear_at);
        logic [15:0] inj_w [28];
        int i = 0;
        int stalled = 0;
        int ip = 0;
        int cyc = 0;
        bit cleared = 1'b0;
        inj_w[0] = HDR;
        for (int k = 0; k < NB; k++) inj_w[k+1] = {8'(8'h40 + k), 8'h00};
        inj_w[27] = TRL;
        while (i < exp_len && cyc < 300) begin
            chk1($sformatf("dump_valid[%0d]", i), valid_o, 1'b1);
            chk16($sformatf("dump_word[%0d]", i), data_o, exp_w[i]);
            chk1($sformatf("dump_busy[%0d]", i), busy_o, 1'b1);
            if (i == stall_at && stalled < stall_len) begin
                rd_i = 1'b0; stalled++;
            end else begin
                rd_i = 1'b1;
            end
            if (inj && ip < 28) begin
                wr_i = 1'b1; data_i = inj_w[ip]; ip++;
            end else begin
                wr_i = 1'b0;
            end
            if (i == clear_at) clear_i = 1'b1;
            step();
            cyc++;
            wr_i = 1'b0;
            if (clear_i) begin
                clear_i = 1'b0;
                cleared = 1'b1;
                break;
            end
            if (rd_i) i++;
        end
        rd_i = 1'b1;
        if (!cleared) chk16("dump_len_in_budget", 16'(i), 16'(exp_len));
        chk1("post_dump_valid", valid_o, 1'b0);
        chk16("post_dump_frames", frames_o, 16'd0);
        chk1("post_dump_busy", busy_o, 1'b0);
    endtask

    initial begin
        reset_i = 1'b0; wr_i = 1'b0; data_i = 16'h0000; clear_i = 1'b0;
        nframes_i = 16'd1; rd_i = 1'b1;
        model_zero();

        // Reset held with the write strobe toggling.
        for (int c = 0; c < 4; c++) begin
            wr_i = c[0]; data_i = HDR;
            step();
            chk16("rst_data", data_o, 16'd0);
            chk1("rst_valid", valid_o, 1'b0);
            chk16("rst_frames", frames_o, 16'd0);
            chk16("rst_bad", bad_cnt_o, 16'd0);
            chk16("rst_drop", drop_cnt_o, 16'd0);
            chk1("rst_busy", busy_o, 1'b0);
        end
        reset_i = 1'b1; wr_i = 1'b0;
        step(); step(); step();
        chk1("idle_valid", valid_o, 1'b0);
        chk1("idle_busy", busy_o, 1'b0);
        chk16("idle_frames", frames_o, 16'd0);

        // One frame of 0x0100 words per dump.
        send_frame(1'b1, 8'd1, 8'd0, TRL, 1'b1);
        build_exp();
        run_dump(-1, 0, 1'b0, -1);
        model_zero();

        // Three frames per dump, bin k carries k.
        nframes_i = 16'd3;
        send_frame(1'b1, 8'd0, 8'd1, TRL, 1'b1);
        chk16("nf3_frames1", frames_o, 16'd1);
        chk1("nf3_valid1", valid_o, 1'b0);
        chk1("nf3_busy1", busy_o, 1'b0);
        send_frame(1'b1, 8'd0, 8'd1, TRL, 1'b1);
        chk16("nf3_frames2", frames_o, 16'd2);
        chk1("nf3_valid2", valid_o, 1'b0);
        send_frame(1'b1, 8'd0, 8'd1, TRL, 1'b1);
        build_exp();
        run_dump(-1, 0, 1'b0, -1);
        model_zero();

        // Bad trailer, then a header in the trailer slot resyncs into a good frame.
        nframes_i = 16'd1;
        send_frame(1'b1, 8'd9, 8'd0, 16'h1234, 1'b0);
        chk16("bad1_cnt", bad_cnt_o, 16'd1);
        chk16("bad1_frames", frames_o, 16'd0);
        chk1("bad1_valid", valid_o, 1'b0);
        send_frame(1'b1, 8'd9, 8'd0, HDR, 1'b0);
        chk16("bad2_cnt", bad_cnt_o, 16'd2);
        chk16("bad2_frames", frames_o, 16'd0);
        send_frame(1'b0, 8'd2, 8'd0, TRL, 1'b1);
        build_exp();
        run_dump(-1, 0, 1'b0, -1);
        chk16("bad_kept", bad_cnt_o, 16'd2);
        model_zero();

        // Backpressure at word 7 with a frame injected during the dump.
        send_frame(1'b1, 8'd1, 8'd1, TRL, 1'b1);
        build_exp();
        run_dump(7, 5, 1'b1, -1);
        chk16("drop_cnt", drop_cnt_o, 16'd1);
        model_zero();
        send_frame(1'b1, 8'd3, 8'd0, TRL, 1'b1);
        build_exp();
        run_dump(-1, 0, 1'b0, -1);
        chk16("drop_kept", drop_cnt_o, 16'd1);
        model_zero();

        // Clear in the middle of a dump, then a fresh run with nframes_i=0.
        send_frame(1'b1, 8'd5, 8'd0, TRL, 1'b1);
        build_exp();
        run_dump(-1, 0, 1'b0, 10);
        chk16("clr_bad", bad_cnt_o, 16'd0);
        chk16("clr_drop", drop_cnt_o, 16'd0);
        model_zero();
        nframes_i = 16'd0;
        send_frame(1'b1, 8'd7, 8'd0, TRL, 1'b1);
        build_exp();
        run_dump(-1, 0, 1'b0, -1);
        model_zero();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
